// File: rtl/fill_ctrl.sv
// Bottle-filling sequencer: owns the BCD target, per-bottle and batch pill counts,
// bottle sequencing with a timed swap gap, the batch alarm and the display page select.
module fill_ctrl #(
    parameter int PAGE_TICKS = 100,
    parameter int SWAP_TICKS = 8,
    parameter int BOTTLES    = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       pause,
    input  logic       pill,
    input  logic       key_mode,
    input  logic       key_sel,
    input  logic       key_up,
    output logic [3:0] max2,
    output logic [3:0] max1,
    output logic [3:0] ten,
    output logic [3:0] one,
    output logic [3:0] seqH,
    output logic [3:0] seqL,
    output logic [3:0] now2,
    output logic [3:0] now1,
    output logic       SET,
    output logic       EN_work,
    output logic       EN_set,
    output logic       print1,
    output logic       motor,
    output logic       alarm
);

    localparam int PW = $clog2(PAGE_TICKS + 1);
    localparam int SW = $clog2(SWAP_TICKS + 1);
    localparam logic [PW-1:0] PAGE_LAST = PW'(PAGE_TICKS - 1);
    localparam logic [SW-1:0] SWAP_LAST = SW'(SWAP_TICKS - 1);
    localparam logic [6:0]    BOTTLES_B = 7'(BOTTLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RUN,
        S_SWAP,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic            r_pillD;
    logic [PW-1:0]   r_pageCnt;
    logic [SW-1:0]   r_swapCnt;

    logic            w_pillEdge;
    logic            w_count;
    logic [7:0]      w_cntInc;
    logic            w_hitTarget;
    logic            w_swapDone;
    logic [6:0]      w_seqBin;
    logic            w_lastBottle;
    logic            w_targetZero;

    logic [7:0]      w_maxN;
    logic [7:0]      w_cntN;
    logic [7:0]      w_seqN;
    logic [7:0]      w_nowN;
    logic            w_setN;
    logic            w_enWorkN;
    logic            w_enSetN;
    logic            w_motorN;
    logic            w_alarmN;
    logic            w_print1N;
    logic [PW-1:0]   w_pageCntN;

    function automatic logic [3:0] bcdInc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [7:0] bcd2Inc(input logic [7:0] v);
        return (v[3:0] >= 4'd9) ? {bcdInc(v[7:4]), 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign w_pillEdge   = pill & ~r_pillD;
    assign w_count      = (r_state == S_RUN) && w_pillEdge && !pause;
    assign w_cntInc     = bcd2Inc({ten, one});
    assign w_hitTarget  = w_count && (w_cntInc == {max2, max1});
    assign w_swapDone   = (r_state == S_SWAP) && (r_swapCnt == SWAP_LAST);
    assign w_seqBin     = 7'(seqH) * 7'd10 + 7'(seqL);
    assign w_lastBottle = (w_seqBin == BOTTLES_B);
    assign w_targetZero = ({max2, max1} == 8'h00);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // start outranks key_mode in IDLE; a zero target never launches a batch
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !w_targetZero) begin
                    w_stateNext = S_RUN;
                end else if (key_mode) begin
                    w_stateNext = S_SETUP;
                end
            end
            S_SETUP: begin
                if (key_mode) begin
                    w_stateNext = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_hitTarget) begin
                    w_stateNext = S_SWAP;
                end
            end
            S_SWAP: begin
                if (w_swapDone) begin
                    w_stateNext = w_lastBottle ? S_DONE : S_RUN;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Next values for every registered output; flags follow the next state so they
    // change on the same edge as the state itself
    always_comb begin
        w_maxN     = {max2, max1};
        w_cntN     = {ten, one};
        w_seqN     = {seqH, seqL};
        w_nowN     = {now2, now1};
        w_setN     = SET;
        w_pageCntN = r_pageCnt;
        w_print1N  = print1;
        case (r_state)
            S_IDLE: begin
                if (w_stateNext == S_RUN) begin
                    w_cntN = 8'h00;
                    w_nowN = 8'h00;
                    w_seqN = 8'h01;
                end
            end
            S_SETUP: begin
                if (key_sel) begin
                    w_setN = ~SET;
                end
                if (key_up) begin
                    if (SET) begin
                        w_maxN = {max2, bcdInc(max1)};
                    end else begin
                        w_maxN = {bcdInc(max2), max1};
                    end
                end
            end
            S_RUN: begin
                if (w_count) begin
                    w_cntN = w_cntInc;
                    w_nowN = bcd2Inc({now2, now1});
                end
            end
            S_SWAP: begin
                if (w_swapDone && !w_lastBottle) begin
                    w_seqN = bcd2Inc({seqH, seqL});
                    w_cntN = 8'h00;
                end
            end
            default: ;
        endcase
        w_enWorkN = (w_stateNext == S_SETUP) || (w_stateNext == S_RUN) || (w_stateNext == S_SWAP);
        w_enSetN  = (w_stateNext == S_RUN) || (w_stateNext == S_SWAP);
        w_motorN  = (w_stateNext == S_RUN) && !pause;
        w_alarmN  = (w_stateNext == S_DONE);
        if ((w_stateNext == S_IDLE) || (w_stateNext == S_SETUP) || (r_state == S_IDLE)) begin
            w_pageCntN = '0;
            w_print1N  = 1'b0;
        end else if (r_pageCnt == PAGE_LAST) begin
            w_pageCntN = '0;
            w_print1N  = ~print1;
        end else begin
            w_pageCntN = r_pageCnt + PW'(1);
        end
    end

    // The swap timer only runs in SWAP, so it is always zero on SWAP entry
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pillD      <= 1'b0;
            r_pageCnt    <= '0;
            r_swapCnt    <= '0;
            {max2, max1} <= 8'h30;
            {ten, one}   <= 8'h00;
            {seqH, seqL} <= 8'h00;
            {now2, now1} <= 8'h00;
            SET          <= 1'b0;
            EN_work      <= 1'b0;
            EN_set       <= 1'b0;
            print1       <= 1'b0;
            motor        <= 1'b0;
            alarm        <= 1'b0;
        end else begin
            r_pillD      <= pill;
            r_pageCnt    <= w_pageCntN;
            r_swapCnt    <= (r_state == S_SWAP) ? r_swapCnt + SW'(1) : '0;
            {max2, max1} <= w_maxN;
            {ten, one}   <= w_cntN;
            {seqH, seqL} <= w_seqN;
            {now2, now1} <= w_nowN;
            SET          <= w_setN;
            EN_work      <= w_enWorkN;
            EN_set       <= w_enSetN;
            print1       <= w_print1N;
            motor        <= w_motorN;
            alarm        <= w_alarmN;
        end
    end

endmodule
